alu_wide_sequencer: RTL and testbench
=====================================

Name: alu_wide_sequencer

Overview:
- Runs 32-bit operations on the 16-bit ALU by issuing two back-to-back ALU passes, one per half-word.
- Arithmetic and shift operations chain the ALU's registered carry flag between the two passes.
- Sits between the control unit, which issues Start/Op/operands, and the ALU port (A, B, FunSel, WF, ALUOut, FlagsOut).
- Assembles the 32-bit result and the combined Z/C/N/V flags.

Parameters:
- HALF_W, 16, ALU data width; only 16 is supported (ALU width is fixed).
- DONE_LEVEL, 0, 0: Done is a 1-cycle pulse; 1: Done stays high until the next Start is accepted.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request; accepted only in IDLE.
- Op  in  3  000 ADD, 001 AND, 010 OR, 011 XOR, 100 LSL, 101 LSR, 110 ASR, 111 PASS (Result = OpA).
- OpA  in  32  first operand; also the shift source.
- OpB  in  32  second operand; ignored for shifts and PASS.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  result and flags valid.
- Result  out  32  registered result.
- FlagZ, FlagC, FlagN, FlagV  out  1 each  32-bit flags.
- AluA  out  16  to ALU A.
- AluB  out  16  to ALU B.
- AluFunSel  out  5  to ALU FunSel.
- AluWF  out  1  to ALU WF.
- AluOut  in  16  from ALU ALUOut (combinational).
- AluFlags  in  4  from ALU FlagsOut; [3]=Z, [2]=C, [1]=N, [0]=V.

Behaviour:
- Reset (async, any state): state=IDLE; Busy=0, Done=0, Result=0, all flags=0; AluWF=0, AluFunSel=5'b10000, AluA=AluB=0. The ALU flag register is not reset, so no sequence may consume carry in pass 1.
- States: IDLE -> P1 -> P2 -> FIN -> DONE -> IDLE. Every state except IDLE lasts exactly 1 cycle.
- IDLE:
  - Start=1: latch Op, OpA, OpB; go to P1.
  - Start while Busy=1: ignored; no queueing.
- Pass 1 / pass 2 FunSel and half order, per Op:
  - ADD: P1 low half, 10100, WF=1; P2 high half, 10101 (ADC), WF=1.
  - LSL: P1 low, 11011, WF=1; P2 high, 11110 (ROL), WF=1.
  - LSR: P1 high, 11100, WF=1; P2 low, 11111 (ROR), WF=1.
  - ASR: P1 high, 11101, WF=1; P2 low, 11111, WF=1.
  - AND/OR/XOR/PASS: P1 low, P2 high, FunSel 10111/11000/11001/10000, WF=0 in both passes.
- In P1 and P2: AluA/AluB carry the selected half-words; AluOut is captured into the matching half of Result on the closing edge.
- FIN:
  - AluWF=0.
  - Capture FlagC=AluFlags[2] and FlagV=AluFlags[0] (values after pass 2).
  - For logic ops and PASS, force FlagC=0 and FlagV=0.
  - Shifts: FlagV=0.
- Self-computed flags: FlagN=Result[31]; FlagZ=(Result==0). Both are computed by the block; ALU Z/N are per-half and not used.
- DONE: Done=1 for 1 cycle when DONE_LEVEL=0, then IDLE.
- Latency: Start sampled at edge 0 -> Done high in cycle 4.
- Result and flags hold their values until the next accepted Start, which clears Done.
- Start in the DONE cycle is not accepted; earliest re-issue is the first IDLE cycle (throughput 1 op / 5 cycles).
- AluWF is 0 in IDLE, FIN and DONE, so flags cannot be corrupted between operations.
- Reset during P1/P2 aborts the operation with no Done. Stale ALU flags are harmless because every pass-1 FunSel ignores carry-in.
- Boundary: carry out of bit 31 (ADD 0xFFFFFFFF+1) gives Result=0, FlagZ=1, FlagC=1.

Decomposition:
- Package alu_seq_pkg holds:
  - the op codes;
  - named FunSel constants (ADD16=10100, ADC16=10101, LSL16=11011, ROL16=11110, LSR16=11100, ASR16=11101, ROR16=11111, AND16, OR16, XOR16, PASSA16);
  - the state encoding;
  - the flag bit indices.
- One combinational sub-module, alu_seq_decode: Op -> {funsel_p1, funsel_p2, wf, hi_first, flags_from_alu}.

Test Plan:
- ADD: OpA=0x0000FFFF, OpB=0x00000001 -> Result=0x00010000, C=0, V=0, Z=0, N=0. P2 must show AluFunSel=10101 with carry from P1. Done in cycle 4.
- ADD overflow: OpA=0x7FFFFFFF, OpB=0x00000001 -> Result=0x80000000, V=1, N=1, C=0. ADD 0xFFFFFFFF+1 -> Result=0, Z=1, C=1.
- LSR: OpA=0x00010000 -> 0x00008000, C=0. ASR 0x80000001 -> 0xC0000000, C=1, N=1. LSL 0x80008000 -> 0x00010000, C=1.
- XOR: 0xFFFF0000 ^ 0x0F0F0F0F -> 0xF0F00F0F, C=0, V=0. AluWF must stay 0 throughout, with the ALU carry preset to 1 beforehand.
- Start held high during P1..DONE -> exactly one operation; next accepted only in IDLE. Busy=1 in cycles 1-4.
- Reset asserted mid-P2 (asynchronously, between edges) -> outputs go to reset values immediately; no Done. A following ADD 1+2 yields 3 regardless of stale ALU carry.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the 32-bit-on-16-bit ALU sequencer: op codes, ALU
// FunSel codes, sequencer states and ALU flag bit positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_LSL  = 3'b100,
    OP_LSR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  localparam logic [4:0] FS_PASSA16 = 5'b10000;
  localparam logic [4:0] FS_ADD16   = 5'b10100;
  localparam logic [4:0] FS_ADC16   = 5'b10101;
  localparam logic [4:0] FS_AND16   = 5'b10111;
  localparam logic [4:0] FS_OR16    = 5'b11000;
  localparam logic [4:0] FS_XOR16   = 5'b11001;
  localparam logic [4:0] FS_LSL16   = 5'b11011;
  localparam logic [4:0] FS_LSR16   = 5'b11100;
  localparam logic [4:0] FS_ASR16   = 5'b11101;
  localparam logic [4:0] FS_ROL16   = 5'b11110;
  localparam logic [4:0] FS_ROR16   = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_FIN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  // Bit positions inside the decoder's flags_from_alu field.
  localparam int unsigned USE_C = 1;
  localparam int unsigned USE_V = 0;

endpackage

// File: rtl/alu_seq_decode.sv
// Maps a 32-bit op to the FunSel pair, write-flag enable, half-word order
// and which ALU flags survive into the 32-bit result flags.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] op_i,
  output logic [4:0] funsel_p1_o,
  output logic [4:0] funsel_p2_o,
  output logic       wf_o,
  output logic       hi_first_o,
  output logic [1:0] flags_from_alu_o
);

  always_comb begin
    funsel_p1_o      = FS_PASSA16;
    funsel_p2_o      = FS_PASSA16;
    wf_o             = 1'b0;
    hi_first_o       = 1'b0;
    flags_from_alu_o = 2'b00;
    case (op_e'(op_i))
      OP_ADD: begin
        funsel_p1_o      = FS_ADD16;
        funsel_p2_o      = FS_ADC16;
        wf_o             = 1'b1;
        flags_from_alu_o = 2'b11;
      end
      OP_LSL: begin
        funsel_p1_o      = FS_LSL16;
        funsel_p2_o      = FS_ROL16;
        wf_o             = 1'b1;
        flags_from_alu_o = 2'b10;
      end
      // Right shifts start at the high half so the bit leaving it lands in
      // the ALU carry and is rotated into the top of the low half.
      OP_LSR: begin
        funsel_p1_o      = FS_LSR16;
        funsel_p2_o      = FS_ROR16;
        wf_o             = 1'b1;
        hi_first_o       = 1'b1;
        flags_from_alu_o = 2'b10;
      end
      OP_ASR: begin
        funsel_p1_o      = FS_ASR16;
        funsel_p2_o      = FS_ROR16;
        wf_o             = 1'b1;
        hi_first_o       = 1'b1;
        flags_from_alu_o = 2'b10;
      end
      OP_AND: begin
        funsel_p1_o = FS_AND16;
        funsel_p2_o = FS_AND16;
      end
      OP_OR: begin
        funsel_p1_o = FS_OR16;
        funsel_p2_o = FS_OR16;
      end
      OP_XOR: begin
        funsel_p1_o = FS_XOR16;
        funsel_p2_o = FS_XOR16;
      end
      OP_PASS: begin
        funsel_p1_o = FS_PASSA16;
        funsel_p2_o = FS_PASSA16;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_wide_sequencer.sv
// Runs 32-bit operations as two chained 16-bit ALU passes and assembles the
// 32-bit result with Z/C/N/V flags.
module alu_wide_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned HALF_W     = 16,
  parameter int unsigned DONE_LEVEL = 0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [2:0]          Op,
  input  logic [2*HALF_W-1:0] OpA,
  input  logic [2*HALF_W-1:0] OpB,
  output logic                Busy,
  output logic                Done,
  output logic [2*HALF_W-1:0] Result,
  output logic                FlagZ,
  output logic                FlagC,
  output logic                FlagN,
  output logic                FlagV,
  output logic [HALF_W-1:0]   AluA,
  output logic [HALF_W-1:0]   AluB,
  output logic [4:0]          AluFunSel,
  output logic                AluWF,
  input  logic [HALF_W-1:0]   AluOut,
  input  logic [3:0]          AluFlags
);

  localparam int unsigned W = 2 * HALF_W;

  state_e        state_q, state_d;
  op_e           op_q;
  logic [W-1:0]  opa_q, opb_q, result_q;
  logic          flag_z_q, flag_c_q, flag_n_q, flag_v_q;
  logic          done_hold_q;

  logic [4:0]    funsel_p1, funsel_p2;
  logic          wf, hi_first, hi_sel;
  logic [1:0]    flags_from_alu;
  logic          unused_alu_zn;

  // ALU Z/N are per half-word; the 32-bit Z/N come from the assembled result.
  assign unused_alu_zn = ^{AluFlags[FLAG_Z], AluFlags[FLAG_N]};

  alu_seq_decode u_decode (
    .op_i             (op_q),
    .funsel_p1_o      (funsel_p1),
    .funsel_p2_o      (funsel_p2),
    .wf_o             (wf),
    .hi_first_o       (hi_first),
    .flags_from_alu_o (flags_from_alu)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    hi_sel    = 1'b0;
    AluFunSel = FS_PASSA16;
    AluWF     = 1'b0;
    AluA      = '0;
    AluB      = '0;
    case (state_q)
      S_IDLE: if (Start) state_d = S_P1;
      S_P1: begin
        state_d   = S_P2;
        hi_sel    = hi_first;
        AluFunSel = funsel_p1;
        AluWF     = wf;
      end
      S_P2: begin
        state_d   = S_FIN;
        hi_sel    = ~hi_first;
        AluFunSel = funsel_p2;
        AluWF     = wf;
      end
      S_FIN:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_P1 || state_q == S_P2) begin
      AluA = hi_sel ? opa_q[W-1 -: HALF_W] : opa_q[HALF_W-1:0];
      AluB = hi_sel ? opb_q[W-1 -: HALF_W] : opb_q[HALF_W-1:0];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_q        <= OP_ADD;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      done_hold_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            op_q        <= op_e'(Op);
            opa_q       <= OpA;
            opb_q       <= OpB;
            done_hold_q <= 1'b0;
          end
        end
        S_P1, S_P2: begin
          if (hi_sel) result_q[W-1 -: HALF_W] <= AluOut;
          else        result_q[HALF_W-1:0]    <= AluOut;
        end
        // ALU flags now reflect pass 2; the result is fully assembled.
        S_FIN: begin
          flag_c_q <= flags_from_alu[USE_C] & AluFlags[FLAG_C];
          flag_v_q <= flags_from_alu[USE_V] & AluFlags[FLAG_V];
          flag_z_q <= (result_q == '0);
          flag_n_q <= result_q[W-1];
        end
        S_DONE:  done_hold_q <= (DONE_LEVEL != 0);
        default: ;
      endcase
    end
  end

  assign Busy   = (state_q != S_IDLE);
  assign Done   = (state_q == S_DONE) | done_hold_q;
  assign Result = result_q;
  assign FlagZ  = flag_z_q;
  assign FlagC  = flag_c_q;
  assign FlagN  = flag_n_q;
  assign FlagV  = flag_v_q;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer with a behavioural 16-bit ALU whose
// flag register is not reset.
module tb_alu_wide_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] OpA, OpB;
  logic        Busy, Done;
  logic [31:0] Result;
  logic        FlagZ, FlagC, FlagN, FlagV;
  logic [15:0] AluA, AluB, AluOut;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [3:0]  AluFlags;

  int n_checks = 0;
  int n_errors = 0;

  alu_wide_sequencer #(.HALF_W(16), .DONE_LEVEL(0)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .Result(Result),
    .FlagZ(FlagZ), .FlagC(FlagC), .FlagN(FlagN), .FlagV(FlagV),
    .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
    .AluOut(AluOut), .AluFlags(AluFlags)
  );

  always #5 Clock = ~Clock;

  // Behavioural ALU: combinational result, flags {Z,C,N,V} registered when WF=1.
  // Flags start with C=1 and V=1 to emulate stale, unreset state.
  logic [3:0]  alu_flags_q = 4'b0101;
  logic [15:0] m_out;
  logic [3:0]  m_next;

  always_comb begin
    logic [16:0] s;
    logic cin, c, v;
    cin   = alu_flags_q[2];
    c     = cin;
    v     = alu_flags_q[0];
    s     = '0;
    m_out = AluA;
    case (AluFunSel)
      5'b10100: begin
        s = {1'b0, AluA} + {1'b0, AluB};
        m_out = s[15:0]; c = s[16];
        v = (AluA[15] == AluB[15]) && (m_out[15] != AluA[15]);
      end
      5'b10101: begin
        s = {1'b0, AluA} + {1'b0, AluB} + {16'd0, cin};
        m_out = s[15:0]; c = s[16];
        v = (AluA[15] == AluB[15]) && (m_out[15] != AluA[15]);
      end
      5'b10111: m_out = AluA & AluB;
      5'b11000: m_out = AluA | AluB;
      5'b11001: m_out = AluA ^ AluB;
      5'b11011: begin m_out = {AluA[14:0], 1'b0};     c = AluA[15]; end
      5'b11100: begin m_out = {1'b0, AluA[15:1]};     c = AluA[0];  end
      5'b11101: begin m_out = {AluA[15], AluA[15:1]}; c = AluA[0];  end
      5'b11110: begin m_out = {AluA[14:0], cin};      c = AluA[15]; end
      5'b11111: begin m_out = {cin, AluA[15:1]};      c = AluA[0];  end
      default:  m_out = AluA;
    endcase
    m_next = {(m_out == 16'd0), c, m_out[15], v};
  end

  always @(posedge Clock) if (AluWF) alu_flags_q <= m_next;
  assign AluOut   = m_out;
  assign AluFlags = alu_flags_q;

  // Issues one op (Start high for edge 0 only) and records 8 cycles of behaviour.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output int done_cnt,
                        output logic [8:0] busy_vec, output logic [8:0] wf_vec,
                        output logic [4:0] fs_p1, output logic [4:0] fs_p2);
    done_cyc = 0; done_cnt = 0; busy_vec = '0; wf_vec = '0; fs_p1 = '0; fs_p2 = '0;
    @(negedge Clock);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(posedge Clock);
    #1 Start = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge Clock);
      busy_vec[cyc] = Busy;
      wf_vec[cyc]   = AluWF;
      if (cyc == 1) fs_p1 = AluFunSel;
      if (cyc == 2) fs_p2 = AluFunSel;
      if (Done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Op = 3'b000; OpA = '0; OpB = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    n_checks++;
    if ({Busy, Done} !== 2'b00) begin n_errors++; $display("FAIL reset_busy_done got=%b exp=00", {Busy, Done}); end
    n_checks++;
    if (Result !== 32'h0) begin n_errors++; $display("FAIL reset_result got=%h exp=00000000", Result); end
    n_checks++;
    if ({FlagZ, FlagC, FlagN, FlagV} !== 4'b0000) begin n_errors++; $display("FAIL reset_flags got=%b exp=0000", {FlagZ, FlagC, FlagN, FlagV}); end
    n_checks++;
    if ({AluWF, AluFunSel, AluA, AluB} !== {1'b0, 5'b10000, 32'h0}) begin
      n_errors++; $display("FAIL reset_alu_port got wf=%b fs=%b a=%h b=%h exp wf=0 fs=10000 a=0 b=0", AluWF, AluFunSel, AluA, AluB);
    end
    Reset = 1'b0;
  endtask

  task automatic test_add();
    int dc, dn; logic [8:0] bv, wv; logic [4:0] f1, f2;
    run_op(3'b000, 32'h0000FFFF, 32'h00000001, dc, dn, bv, wv, f1, f2);
    n_checks++;
    if (Result !== 32'h00010000) begin n_errors++; $display("FAIL add_result got=%h exp=00010000", Result); end
    n_checks++;
    if ({FlagZ, FlagC, FlagN, FlagV} !== 4'b0000) begin n_errors++; $display("FAIL add_flags got=%b exp=0000", {FlagZ, FlagC, FlagN, FlagV}); end
    n_checks++;
    if ({f1, f2} !== {5'b10100, 5'b10101}) begin n_errors++; $display("FAIL add_funsel got=%b/%b exp=10100/10101", f1, f2); end
    n_checks++;
    if (wv !== 9'b000000110) begin n_errors++; $display("FAIL add_wf got=%b exp=000000110", wv); end
    n_checks++;
    if (dc !== 4 || dn !== 1) begin n_errors++; $display("FAIL add_done_timing got cycle=%0d count=%0d exp cycle=4 count=1", dc, dn); end
    n_checks++;
    if (bv !== 9'b000011110) begin n_errors++; $display("FAIL add_busy got=%b exp=000011110", bv); end
  endtask

  task automatic test_add_boundaries();
    int dc, dn; logic [8:0] bv, wv; logic [4:0] f1, f2;
    run_op(3'b000, 32'hFFFFFFFF, 32'h00000001, dc, dn, bv, wv, f1, f2);
    n_checks++;
    if (Result !== 32'h00000000) begin n_errors++; $display("FAIL add_wrap_result got=%h exp=00000000", Result); end
    n_checks++;
    if ({FlagZ, FlagC, FlagN, FlagV} !== 4'b1100) begin n_errors++; $display("FAIL add_wrap_flags got=%b exp=1100", {FlagZ, FlagC, FlagN, FlagV}); end
    run_op(3'b000, 32'h7FFFFFFF, 32'h00000001, dc, dn, bv, wv, f1, f2);
    n_checks++;
    if (Result !== 32'h80000000) begin n_errors++; $display("FAIL add_ovf_result got=%h exp=80000000", Result); end
    n_checks++;
    if ({FlagZ, FlagC, FlagN, FlagV} !== 4'b0011) begin n_errors++; $display("FAIL add_ovf_flags got=%b exp=0011", {FlagZ, FlagC, FlagN, FlagV}); end
  endtask

  task automatic test_shifts();
    int dc, dn; logic [8:0] bv, wv; logic [4:0] f1, f2;
    run_op(3'b101, 32'h00010000, 32'hDEADBEEF, dc, dn, bv, wv, f1, f2);
    n_checks++;
    if (Result !== 32'h00008000) begin n_errors++; $display("FAIL lsr_result got=%h exp=00008000", Result); end
    n_checks++;
    if ({FlagZ, FlagC, FlagN, FlagV} !== 4'b0000) begin n_errors++; $display("FAIL lsr_flags got=%b exp=0000", {FlagZ, FlagC, FlagN, FlagV}); end
    n_checks++;
    if ({f1, f2} !== {5'b11100, 5'b11111}) begin n_errors++; $display("FAIL lsr_funsel got=%b/%b exp=11100/11111", f1, f2); end
    run_op(3'b110, 32'h80000001, 32'h12345678, dc, dn, bv, wv, f1, f2);
    n_checks++;
    if (Result !== 32'hC0000000) begin n_errors++; $display("FAIL asr_result got=%h exp=C0000000", Result); end
    n_checks++;
    if ({FlagZ, FlagC, FlagN, FlagV} !== 4'b0110) begin n_errors++; $display("FAIL asr_flags got=%b exp=0110", {FlagZ, FlagC, FlagN, FlagV}); end
    run_op(3'b100, 32'h80008000, 32'hFFFFFFFF, dc, dn, bv, wv, f1, f2);
    n_checks++;
    if (Result !== 32'h00010000) begin n_errors++; $display("FAIL lsl_result got=%h exp=00010000", Result); end
    n_checks++;
    if ({FlagZ, FlagC, FlagN, FlagV} !== 4'b0100) begin n_errors++; $display("FAIL lsl_flags got=%b exp=0100", {FlagZ, FlagC, FlagN, FlagV}); end
    n_checks++;
    if ({f1, f2} !== {5'b11011, 5'b11110}) begin n_errors++; $display("FAIL lsl_funsel got=%b/%b exp=11011/11110", f1, f2); end
  endtask

  // Runs after LSL, so the ALU carry (and stale V) are 1 going in.
  task automatic test_logic();
    int dc, dn; logic [8:0] bv, wv; logic [4:0] f1, f2;
    run_op(3'b011, 32'hFFFF0000, 32'h0F0F0F0F, dc, dn, bv, wv, f1, f2);
    n_checks++;
    if (Result !== 32'hF0F00F0F) begin n_errors++; $display("FAIL xor_result got=%h exp=F0F00F0F", Result); end
    n_checks++;
    if ({FlagZ, FlagC, FlagN, FlagV} !== 4'b0010) begin n_errors++; $display("FAIL xor_flags got=%b exp=0010", {FlagZ, FlagC, FlagN, FlagV}); end
    n_checks++;
    if (wv !== 9'b000000000) begin n_errors++; $display("FAIL xor_wf got=%b exp=000000000", wv); end
    n_checks++;
    if ({f1, f2} !== {5'b11001, 5'b11001}) begin n_errors++; $display("FAIL xor_funsel got=%b/%b exp=11001/11001", f1, f2); end
    run_op(3'b001, 32'hF0F01234, 32'h0FF0FF00, dc, dn, bv, wv, f1, f2);
    n_checks++;
    if (Result !== 32'h00F01200) begin n_errors++; $display("FAIL and_result got=%h exp=00F01200", Result); end
    run_op(3'b010, 32'h80000001, 32'h00008000, dc, dn, bv, wv, f1, f2);
    n_checks++;
    if ({Result, FlagZ, FlagC, FlagN, FlagV} !== {32'h80008001, 4'b0010}) begin
      n_errors++; $display("FAIL or_result_flags got=%h/%b exp=80008001/0010", Result, {FlagZ, FlagC, FlagN, FlagV});
    end
    run_op(3'b111, 32'h00000000, 32'hFFFFFFFF, dc, dn, bv, wv, f1, f2);
    n_checks++;
    if ({Result, FlagZ, FlagC, FlagN, FlagV} !== {32'h00000000, 4'b1000}) begin
      n_errors++; $display("FAIL pass_result_flags got=%h/%b exp=00000000/1000", Result, {FlagZ, FlagC, FlagN, FlagV});
    end
  endtask

  // Start held high from edge 0 through cycle 5; operands change while busy.
  task automatic test_back_to_back();
    logic [10:0] bv, dv;
    logic [31:0] r4;
    bv = '0; dv = '0; r4 = '0;
    @(negedge Clock);
    Start = 1'b1; Op = 3'b000; OpA = 32'd5; OpB = 32'd7;
    @(posedge Clock);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge Clock);
      bv[cyc] = Busy;
      dv[cyc] = Done;
      if (cyc == 1) begin OpA = 32'h100; OpB = 32'h200; end
      if (cyc == 4) r4 = Result;
      if (cyc == 6) Start = 1'b0;
    end
    n_checks++;
    if (r4 !== 32'd12) begin n_errors++; $display("FAIL b2b_first_result got=%h exp=0000000c", r4); end
    n_checks++;
    if (bv !== 11'b01111011110) begin n_errors++; $display("FAIL b2b_busy got=%b exp=01111011110", bv); end
    n_checks++;
    if (dv !== 11'b01000010000) begin n_errors++; $display("FAIL b2b_done got=%b exp=01000010000", dv); end
    n_checks++;
    if (Result !== 32'h300) begin n_errors++; $display("FAIL b2b_second_result got=%h exp=00000300", Result); end
  endtask

  task automatic test_reset_abort();
    int dc, dn; logic [8:0] bv, wv; logic [4:0] f1, f2;
    int seen_done, seen_busy;
    seen_done = 0; seen_busy = 0;
    @(negedge Clock);
    Start = 1'b1; Op = 3'b000; OpA = 32'h0001FFFF; OpB = 32'h00000003;
    @(posedge Clock);
    #1 Start = 1'b0;
    @(posedge Clock);
    #3 Reset = 1'b1;
    #1;
    n_checks++;
    if ({Busy, Done, AluWF} !== 3'b000) begin n_errors++; $display("FAIL abort_busy_done_wf got=%b exp=000", {Busy, Done, AluWF}); end
    n_checks++;
    if ({AluFunSel, AluA, AluB} !== {5'b10000, 32'h0}) begin
      n_errors++; $display("FAIL abort_alu_port got fs=%b a=%h b=%h exp fs=10000 a=0 b=0", AluFunSel, AluA, AluB);
    end
    n_checks++;
    if ({Result, FlagZ, FlagC, FlagN, FlagV} !== 36'h0) begin
      n_errors++; $display("FAIL abort_result_flags got=%h/%b exp=00000000/0000", Result, {FlagZ, FlagC, FlagN, FlagV});
    end
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge Clock);
      if (Done === 1'b1) seen_done++;
      if (Busy === 1'b1) seen_busy++;
    end
    n_checks++;
    if (seen_done != 0 || seen_busy != 0) begin
      n_errors++; $display("FAIL abort_no_done got done=%0d busy=%0d exp 0/0", seen_done, seen_busy);
    end
    run_op(3'b000, 32'd1, 32'd2, dc, dn, bv, wv, f1, f2);
    n_checks++;
    if ({Result, FlagZ, FlagC, FlagN, FlagV} !== {32'd3, 4'b0000}) begin
      n_errors++; $display("FAIL post_abort_add got=%h/%b exp=00000003/0000", Result, {FlagZ, FlagC, FlagN, FlagV});
    end
    n_checks++;
    if (dc !== 4) begin n_errors++; $display("FAIL post_abort_done got=%0d exp=4", dc); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_boundaries();
    test_shifts();
    test_logic();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
